// File: rtl/game_flow_controller.sv
// Game sequencer: button edge decode, game state machine, round strobes and
// HUD counters (score, lives, wave) for the Space Invaders datapath.
module game_flow_controller #(
    parameter int START_LIVES    = 3,
    parameter int POINTS_PER_HIT = 10,
    parameter int SCORE_MAX      = 999,
    parameter int RESPAWN_FRAMES = 120,
    parameter int CLEAR_FRAMES   = 90,
    parameter int WAVE_MAX       = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       alien_hit,
    input  logic       player_hit,
    input  logic       aliens_cleared,
    input  logic       invasion,
    output logic [2:0] state,
    output logic       run_en,
    output logic       paused,
    output logic       round_reload,
    output logic       respawn,
    output logic [9:0] score,
    output logic [1:0] lives,
    output logic [3:0] wave
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_PLAYING    = 3'd1;
    localparam logic [2:0] S_PAUSED     = 3'd2;
    localparam logic [2:0] S_LIFE_LOST  = 3'd3;
    localparam logic [2:0] S_WAVE_CLEAR = 3'd4;
    localparam logic [2:0] S_GAME_OVER  = 3'd5;

    localparam int TMAX    = (RESPAWN_FRAMES > CLEAR_FRAMES) ? RESPAWN_FRAMES : CLEAR_FRAMES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    logic               start_prev, pause_prev;
    logic               start_rise, pause_rise;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [2:0]         state_n;
    logic [9:0]         score_n;
    logic [1:0]         lives_n;
    logic [3:0]         wave_n;
    logic               reload_n, respawn_n;
    logic [10:0]        score_sum;

    assign start_rise = start_btn & ~start_prev;
    assign pause_rise = pause_btn & ~pause_prev;
    assign score_sum  = {1'b0, score} + 11'(POINTS_PER_HIT);

    always_comb begin
        state_n   = state;
        score_n   = score;
        lives_n   = lives;
        wave_n    = wave;
        timer_n   = timer;
        reload_n  = 1'b0;
        respawn_n = 1'b0;
        case (state)
            S_IDLE: if (start_rise) begin
                state_n  = S_PLAYING;
                score_n  = '0;
                lives_n  = 2'(START_LIVES);
                wave_n   = 4'd1;
                reload_n = 1'b1;
            end
            S_PLAYING: begin
                // Scoring is independent of whatever transition wins this cycle.
                if (alien_hit)
                    score_n = (score_sum > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_sum[9:0];
                if (invasion) begin
                    state_n = S_GAME_OVER;
                end else if (player_hit) begin
                    lives_n = lives - 2'd1;
                    if (lives == 2'd1) begin
                        state_n = S_GAME_OVER;
                    end else begin
                        state_n = S_LIFE_LOST;
                        timer_n = TIMER_W'(RESPAWN_FRAMES);
                    end
                end else if (aliens_cleared) begin
                    state_n = S_WAVE_CLEAR;
                    timer_n = TIMER_W'(CLEAR_FRAMES);
                end else if (pause_rise) begin
                    state_n = S_PAUSED;
                end
            end
            S_PAUSED: if (pause_rise) state_n = S_PLAYING;
            S_LIFE_LOST: if (frame_tick) begin
                if (timer <= TIMER_W'(1)) begin
                    timer_n   = '0;
                    state_n   = S_PLAYING;
                    respawn_n = 1'b1;
                end else begin
                    timer_n = timer - TIMER_W'(1);
                end
            end
            S_WAVE_CLEAR: if (frame_tick) begin
                if (timer <= TIMER_W'(1)) begin
                    timer_n  = '0;
                    state_n  = S_PLAYING;
                    reload_n = 1'b1;
                    wave_n   = (wave < 4'(WAVE_MAX)) ? wave + 4'd1 : 4'(WAVE_MAX);
                end else begin
                    timer_n = timer - TIMER_W'(1);
                end
            end
            S_GAME_OVER: if (start_rise) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // History flops reset high so a button held through reset gives no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_prev   <= 1'b1;
            pause_prev   <= 1'b1;
            state        <= S_IDLE;
            run_en       <= 1'b0;
            paused       <= 1'b0;
            round_reload <= 1'b0;
            respawn      <= 1'b0;
            score        <= '0;
            lives        <= '0;
            wave         <= '0;
            timer        <= '0;
        end else begin
            start_prev   <= start_btn;
            pause_prev   <= pause_btn;
            state        <= state_n;
            run_en       <= (state_n == S_PLAYING);
            paused       <= (state_n == S_PAUSED);
            round_reload <= reload_n;
            respawn      <= respawn_n;
            score        <= score_n;
            lives        <= lives_n;
            wave         <= wave_n;
            timer        <= timer_n;
        end
    end
endmodule
